multiplier_digit_serial: RTL and testbench
==========================================

// Module: multiplier_digit_serial
// PURPOSE
//   Multi-cycle unsigned WIDTH x WIDTH multiplier built around one multiplier2x2.
//   Splits both operands into 2-bit digits and feeds one digit pair per cycle to
//   the internal multiplier2x2 instance. Consumes its 4-bit partial product and
//   shift-accumulates it into a 2*WIDTH result.
//   Valid/ready handshake on both sides; sits between an operand source and a result sink.
// PARAMETERS
//   WIDTH   8   operand width in bits; must be even and >= 2; N = WIDTH/2 digits
// PORTS
//   clk           input   1          rising-edge clock
//   rst_n         input   1          asynchronous reset, active low
//   in_valid      input   1          operand pair available
//   in_ready      output  1          block can accept operands (IDLE only)
//   multiplicand  input   WIDTH      unsigned operand A
//   multiplier    input   WIDTH      unsigned operand B
//   out_valid     output  1          product valid (DONE only)
//   out_ready     input   1          sink accepts product
//   product       output  2*WIDTH    unsigned A*B, held stable while out_valid
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE, in_ready=1, out_valid=0, product=0,
//     operand regs=0, digit indices i=j=0, accumulator=0. Abort any run in progress.
//   - States: IDLE, RUN, DONE. Registered state; in_ready=(state==IDLE),
//     out_valid=(state==DONE).
//   - IDLE: on in_valid&&in_ready at edge: latch multiplicand->A, multiplier->B,
//     clear acc, i=0, j=0, go RUN. Otherwise stay.
//   - RUN (one digit pair per cycle): A digit i = A[2i+1:2i], B digit j = B[2j+1:2j]
//     drive the multiplier2x2 inputs combinationally. At each edge:
//     acc <= acc + (pp4 << 2*(i+j)), with pp4 zero-extended to 2*WIDTH.
//     Index order: j runs 0..N-1 fastest; on j==N-1, j<=0 and i<=i+1.
//     At the edge processing i==N-1 && j==N-1: go DONE, product <= final acc.
//   - Accumulator width 2*WIDTH; no overflow is possible (max (2^W-1)^2).
//     No truncation.
//   - Latency: accept edge at cycle t -> out_valid high from cycle t+N*N
//     (exactly N*N RUN cycles; WIDTH=2 -> 1 cycle). No early exit on zero operands.
//   - DONE: hold product and out_valid until out_ready=1 at an edge, then go IDLE.
//     out_valid deasserts the following cycle. The new operands are not accepted
//     in that same cycle.
//   - in_valid during RUN/DONE: ignored; in_ready=0, so no operand is captured.
//     Inputs need not be stable after the accept edge.
//   - product keeps the last result after the handoff, until the next DONE or reset.
//   - Reset asserted mid-RUN or in DONE: immediate return to reset values.
//     The partial result is discarded.
//   - Throughput: one multiplication per N*N+2 cycles minimum (accept, N*N RUN, handoff).
// TESTING
//   1. WIDTH=8, A=0xFF, B=0xFF, out_ready=1 -> out_valid 16 cycles after accept,
//      product=0xFE01.
//   2. WIDTH=8, A=0x00, B=0xA5 -> product=0x0000 after 16 cycles;
//      then A=0x12, B=0x34 -> product=0x03A8.
//   3. Backpressure: A=0x0F, B=0x10, out_ready=0 for 5 cycles after DONE ->
//      out_valid and product=0x00F0 held stable; in_ready=0; IDLE one cycle after out_ready=1.
//   4. in_valid held high with A=0x03, B=0x03 during RUN -> not captured;
//      first product stays correct. Next accept only when in_ready=1.
//   5. rst_n pulsed low at RUN cycle 7 (A=0xC8, B=0x37) -> outputs at reset values
//      asynchronously; no out_valid; a fresh run then gives product=0x2AF8.
//   6. WIDTH=2 exhaustive, all 16 operand pairs -> product=A*B one cycle after each accept.

Source files
------------

// File: rtl/multiplier_digit_serial.sv
// Digit-serial unsigned WIDTH x WIDTH multiplier: one 2-bit digit pair per cycle through a
// single 2x2 multiplier, shift-accumulated into a 2*WIDTH product with valid/ready handshakes.

module multiplier2x2 (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output logic [3:0] o_p
);

    assign o_p = {2'b00, i_a} * {2'b00, i_b};

endmodule

module multiplier_digit_serial #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int N  = WIDTH / 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [IW-1:0]      r_i;
    logic [IW-1:0]      r_j;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_product;

    logic [1:0]         w_a_dig;
    logic [1:0]         w_b_dig;
    logic [3:0]         w_pp;
    logic [2*WIDTH-1:0] w_pp_ext;
    logic [IW:0]        w_sum;
    logic [2*WIDTH-1:0] w_term;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_a_dig = r_a[{r_i, 1'b0} +: 2];
    assign w_b_dig = r_b[{r_j, 1'b0} +: 2];

    multiplier2x2 u_mul2x2 (
        .i_a (w_a_dig),
        .i_b (w_b_dig),
        .o_p (w_pp)
    );

    always_comb begin
        w_pp_ext      = '0;
        w_pp_ext[3:0] = w_pp;
    end

    // Digit weights: digit i of A times digit j of B lands at bit 2*(i+j).
    assign w_sum      = {1'b0, r_i} + {1'b0, r_j};
    assign w_term     = w_pp_ext << {w_sum, 1'b0};
    assign w_acc_next = r_acc + w_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_acc     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= multiplicand;
                        r_b     <= multiplier;
                        r_acc   <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_next;
                    if (r_j == LAST) begin
                        r_j <= '0;
                        if (r_i == LAST) begin
                            r_i       <= '0;
                            r_product <= w_acc_next;
                            r_state   <= ST_DONE;
                        end else begin
                            r_i <= r_i + IW'(1);
                        end
                    end else begin
                        r_j <= r_j + IW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign product   = r_product;

endmodule

// File: tb/tb_multiplier_digit_serial.sv
// Directed self-checking bench for multiplier_digit_serial (WIDTH=8 and WIDTH=2 instances).

module tb_multiplier_digit_serial;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;

    logic        in_valid2;
    logic        in_ready2;
    logic [1:0]  multiplicand2;
    logic [1:0]  multiplier2;
    logic        out_valid2;
    logic        out_ready2;
    logic [3:0]  product2;

    int n_pass;
    int n_total;

    multiplier_digit_serial #(.WIDTH(8)) u_dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product)
    );

    multiplier_digit_serial #(.WIDTH(2)) u_dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid2),
        .in_ready     (in_ready2),
        .multiplicand (multiplicand2),
        .multiplier   (multiplier2),
        .out_valid    (out_valid2),
        .out_ready    (out_ready2),
        .product      (product2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one edge; returns with in_valid dropped.
    task automatic accept8(input logic [7:0] a, input logic [7:0] b);
        multiplicand = a;
        multiplier   = b;
        in_valid     = 1'b1;
        step();
        in_valid     = 1'b0;
        multiplicand = 8'hxx;
        multiplier   = 8'hxx;
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h0000)
            $display("FAIL reset: got rdy=%b vld=%b prod=%h, want rdy=1 vld=0 prod=0000",
                     in_ready, out_valid, product);
        else n_pass++;
    endtask

    task automatic test_max();
        int lat;
        out_ready = 1'b1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL max_ready: got %b want 1", in_ready);
        else n_pass++;
        accept8(8'hFF, 8'hFF);
        wait_done8(lat);
        n_total++;
        if (lat !== 16) $display("FAIL max_latency: got %0d want 16", lat);
        else n_pass++;
        n_total++;
        if (out_valid !== 1'b1 || product !== 16'hFE01)
            $display("FAIL max_product: got vld=%b prod=%h want vld=1 prod=fe01",
                     out_valid, product);
        else n_pass++;
        step();
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 16'hFE01)
            $display("FAIL max_handoff: got vld=%b rdy=%b prod=%h want vld=0 rdy=1 prod=fe01",
                     out_valid, in_ready, product);
        else n_pass++;
    endtask

    task automatic test_zero_then_next();
        int lat;
        out_ready = 1'b1;
        accept8(8'h00, 8'hA5);
        wait_done8(lat);
        n_total++;
        if (lat !== 16 || product !== 16'h0000)
            $display("FAIL zero_operand: got lat=%0d prod=%h want lat=16 prod=0000", lat, product);
        else n_pass++;
        step();
        accept8(8'h12, 8'h34);
        wait_done8(lat);
        n_total++;
        if (lat !== 16 || product !== 16'h03A8)
            $display("FAIL next_operand: got lat=%0d prod=%h want lat=16 prod=03a8", lat, product);
        else n_pass++;
        step();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        out_ready = 1'b0;
        accept8(8'h0F, 8'h10);
        wait_done8(lat);
        n_total++;
        if (lat !== 16 || product !== 16'h00F0)
            $display("FAIL bp_product: got lat=%0d prod=%h want lat=16 prod=00f0", lat, product);
        else n_pass++;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== 16'h00F0) bad++;
        end
        n_total++;
        if (bad != 0)
            $display("FAIL bp_hold: %0d bad cycles, last vld=%b rdy=%b prod=%h want 0 bad",
                     bad, out_valid, in_ready, product);
        else n_pass++;
        out_ready = 1'b1;
        step();
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_in_valid_during_run();
        int lat;
        int bad;
        out_ready = 1'b0;
        accept8(8'h0F, 8'h0F);
        multiplicand = 8'h03;
        multiplier   = 8'h03;
        in_valid     = 1'b1;
        bad = 0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready !== 1'b0) bad++;
            step();
            lat++;
        end
        n_total++;
        if (bad != 0 || lat !== 16)
            $display("FAIL busy_ready: got %0d ready cycles lat=%0d want 0 and 16", bad, lat);
        else n_pass++;
        n_total++;
        if (product !== 16'h00E1)
            $display("FAIL busy_product: got %h want 00e1", product);
        else n_pass++;
        out_ready = 1'b1;
        step();
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL busy_idle: got rdy=%b want 1", in_ready);
        else n_pass++;
        step();
        in_valid = 1'b0;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL busy_accept: got rdy=%b want 0", in_ready);
        else n_pass++;
        wait_done8(lat);
        n_total++;
        if (lat !== 16 || product !== 16'h0009)
            $display("FAIL busy_second: got lat=%0d prod=%h want lat=16 prod=0009", lat, product);
        else n_pass++;
        step();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen;
        out_ready = 1'b1;
        accept8(8'hC8, 8'h37);
        for (int k = 0; k < 7; k++) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h0000)
            $display("FAIL async_reset: got rdy=%b vld=%b prod=%h want rdy=1 vld=0 prod=0000",
                     in_ready, out_valid, product);
        else n_pass++;
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
        end
        n_total++;
        if (seen != 0) $display("FAIL reset_discard: got %0d bad cycles want 0", seen);
        else n_pass++;
        accept8(8'hC8, 8'h37);
        wait_done8(lat);
        n_total++;
        if (lat !== 16 || product !== 16'h2AF8)
            $display("FAIL reset_fresh: got lat=%0d prod=%h want lat=16 prod=2af8", lat, product);
        else n_pass++;
        step();
    endtask

    task automatic test_width2_exhaustive();
        logic [3:0] exp;
        out_ready2 = 1'b1;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                exp           = 4'(a * b);
                multiplicand2 = 2'(a);
                multiplier2   = 2'(b);
                in_valid2     = 1'b1;
                step();
                in_valid2     = 1'b0;
                step();
                n_total++;
                if (out_valid2 !== 1'b1 || product2 !== exp)
                    $display("FAIL w2_%0dx%0d: got vld=%b prod=%h want vld=1 prod=%h",
                             a, b, out_valid2, product2, exp);
                else n_pass++;
                step();
            end
        end
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        multiplicand  = '0;
        multiplier    = '0;
        out_ready     = 1'b0;
        in_valid2     = 1'b0;
        multiplicand2 = '0;
        multiplier2   = '0;
        out_ready2    = 1'b0;
        step();
        step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_reset();
        test_max();
        test_zero_then_next();
        test_backpressure();
        test_in_valid_during_run();
        test_reset_mid_run();
        test_width2_exhaustive();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
